// File: rtl/program_memory_loadable_if.sv
`default_nettype none
// ==========================================================================
// program_memory_loadable_if: load port and fetch port of the program store
// Rev 1.0
// ==========================================================================
interface program_memory_loadable_if #(
  parameter int INSTR_W = 21,
  parameter int ADDR_W  = 4
);
  logic               load_start;
  logic               load_valid;
  logic [INSTR_W-1:0] load_data;
  logic               load_last;
  logic               load_ready;
  logic               load_done;
  logic               busy;
  logic               fetch_en;
  logic [ADDR_W-1:0]  pc;
  logic [INSTR_W-1:0] instruction;
  logic               instr_valid;

  modport master (
    output load_start, load_valid, load_data, load_last, fetch_en, pc,
    input  load_ready, load_done, busy, instruction, instr_valid
  );

  modport slave (
    input  load_start, load_valid, load_data, load_last, fetch_en, pc,
    output load_ready, load_done, busy, instruction, instr_valid
  );
endinterface
`default_nettype wire

// File: rtl/program_memory_loadable.sv
`default_nettype none
// ==========================================================================
// program_memory_loadable: run-time loadable instruction store, 1-cycle fetch
// Rev 1.0
// ==========================================================================
module program_memory_loadable #(
  parameter int INSTR_W = 21,
  parameter int ADDR_W  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  program_memory_loadable_if.slave bus
);
  localparam int                DEPTH     = 2**ADDR_W;
  localparam logic [0:0]        IDLE      = 1'b0;
  localparam logic [0:0]        LOAD      = 1'b1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  logic [0:0]         state_q, state_d;
  logic [ADDR_W-1:0]  wptr_q, wptr_d;
  logic [DEPTH-1:0]   loaded_q, loaded_d;
  logic [INSTR_W-1:0] instruction_q, instruction_d;
  logic               instr_valid_q, instr_valid_d;
  logic               load_done_q, load_done_d;

  // Storage is never reset; the loaded mask hides stale contents instead.
  logic [INSTR_W-1:0] mem_q [DEPTH];

  logic in_load;
  logic accept;
  logic last_word;
  logic fetch_ok;

  assign in_load   = (state_q == LOAD);
  assign accept    = bus.load_valid & in_load;
  assign last_word = bus.load_last | (wptr_q == LAST_ADDR);
  assign fetch_ok  = bus.fetch_en & ~in_load;

  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    loaded_d    = loaded_q;
    load_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.load_start) begin
          state_d  = LOAD;
          wptr_d   = '0;
          loaded_d = '0;
        end
      end
      LOAD: begin
        if (accept) begin
          loaded_d[wptr_q] = 1'b1;
          if (last_word) begin
            state_d     = IDLE;
            load_done_d = 1'b1;
          end
          // Hold at the top address so the pointer never wraps.
          if (wptr_q != LAST_ADDR) begin
            wptr_d = wptr_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    instruction_d = instruction_q;
    instr_valid_d = fetch_ok;
    if (fetch_ok) begin
      instruction_d = loaded_q[bus.pc] ? mem_q[bus.pc] : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      wptr_q        <= '0;
      loaded_q      <= '0;
      instruction_q <= '0;
      instr_valid_q <= 1'b0;
      load_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      wptr_q        <= wptr_d;
      loaded_q      <= loaded_d;
      instruction_q <= instruction_d;
      instr_valid_q <= instr_valid_d;
      load_done_q   <= load_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wptr_q] <= bus.load_data;
    end
  end

  assign bus.busy        = in_load;
  assign bus.load_ready  = in_load;
  assign bus.load_done   = load_done_q;
  assign bus.instruction = instruction_q;
  assign bus.instr_valid = instr_valid_q;
endmodule
`default_nettype wire

// File: tb/tb_program_memory_loadable.sv
`default_nettype none
// ==========================================================================
// tb_program_memory_loadable: directed checks of load, fetch and reset abort
// Rev 1.0
// ==========================================================================
module tb_program_memory_loadable;
  localparam int INSTR_W = 21;
  localparam int ADDR_W  = 4;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  program_memory_loadable_if #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W)) bus ();

  program_memory_loadable #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.load_last  = 1'b0;
    bus.fetch_en   = 1'b0;
    bus.pc         = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
    vectors++; if (bus.load_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready: got %b expected 0", bus.load_ready); end
    vectors++; if (bus.load_done !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %b expected 0", bus.load_done); end
    vectors++; if (bus.instr_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b expected 0", bus.instr_valid); end
    vectors++; if (bus.instruction !== 21'h0) begin miscompares++; $display("FAIL rst_instr: got %h expected 0", bus.instruction); end
    bus.fetch_en = 1'b1;
    bus.pc       = 4'd5;
    tick();
    vectors++; if (bus.instruction !== 21'h0) begin miscompares++; $display("FAIL nop_fetch_instr: got %h expected 0", bus.instruction); end
    vectors++; if (bus.instr_valid !== 1'b1) begin miscompares++; $display("FAIL nop_fetch_valid: got %b expected 1", bus.instr_valid); end
    bus.fetch_en = 1'b0;
    tick();
    vectors++; if (bus.instr_valid !== 1'b0) begin miscompares++; $display("FAIL no_fetch_valid: got %b expected 0", bus.instr_valid); end
  endtask

  task automatic test_short_load();
    logic [INSTR_W-1:0] words [3];
    logic [INSTR_W-1:0] exp   [4];
    words = '{21'h100003, 21'h100005, 21'h005300};
    exp   = '{21'h100003, 21'h100005, 21'h005300, 21'h000000};
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    vectors++; if (bus.busy !== 1'b1 || bus.load_ready !== 1'b1) begin miscompares++; $display("FAIL short_enter: busy %b ready %b expected 1 1", bus.busy, bus.load_ready); end
    for (int i = 0; i < 3; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = words[i];
      bus.load_last  = (i == 2);
      tick();
      if (i < 2) begin
        vectors++; if (bus.busy !== 1'b1 || bus.load_done !== 1'b0) begin miscompares++; $display("FAIL short_mid%0d: busy %b done %b expected 1 0", i, bus.busy, bus.load_done); end
      end
    end
    vectors++; if (bus.load_done !== 1'b1 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL short_exit: done %b busy %b expected 1 0", bus.load_done, bus.busy); end
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    tick();
    vectors++; if (bus.load_done !== 1'b0) begin miscompares++; $display("FAIL short_done_pulse: got %b expected 0", bus.load_done); end
    for (int i = 0; i < 4; i++) begin
      bus.fetch_en = 1'b1;
      bus.pc       = 4'(i);
      tick();
      vectors++; if (bus.instruction !== exp[i] || bus.instr_valid !== 1'b1) begin miscompares++; $display("FAIL short_fetch_pc%0d: got %h/%b expected %h/1", i, bus.instruction, bus.instr_valid, exp[i]); end
    end
    bus.fetch_en = 1'b0;
    tick();
    vectors++; if (bus.instruction !== 21'h0 || bus.instr_valid !== 1'b0) begin miscompares++; $display("FAIL short_hold: got %h/%b expected 000000/0", bus.instruction, bus.instr_valid); end
  endtask

  task automatic test_full_load();
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = 21'h0F0A00 + 21'(i);
      tick();
      if (i == 14) begin
        vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL full_busy14: got %b expected 1", bus.busy); end
      end
    end
    vectors++; if (bus.busy !== 1'b0 || bus.load_done !== 1'b1) begin miscompares++; $display("FAIL full_autoexit: busy %b done %b expected 0 1", bus.busy, bus.load_done); end
    // A surplus word after auto-exit must not land anywhere.
    bus.load_data = 21'h1FFFFF;
    tick();
    bus.load_valid = 1'b0;
    vectors++; if (bus.busy !== 1'b0 || bus.load_done !== 1'b0) begin miscompares++; $display("FAIL full_after: busy %b done %b expected 0 0", bus.busy, bus.load_done); end
    bus.fetch_en = 1'b1;
    bus.pc       = 4'd0;
    tick();
    vectors++; if (bus.instruction !== 21'h0F0A00) begin miscompares++; $display("FAIL full_pc0: got %h expected 0f0a00", bus.instruction); end
    bus.pc = 4'd15;
    tick();
    vectors++; if (bus.instruction !== 21'h0F0A0F || bus.instr_valid !== 1'b1) begin miscompares++; $display("FAIL full_pc15: got %h/%b expected 0f0a0f/1", bus.instruction, bus.instr_valid); end
  endtask

  task automatic test_fetch_during_load();
    bus.fetch_en   = 1'b1;
    bus.pc         = 4'd3;
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    bus.pc         = 4'd1;
    vectors++; if (bus.instruction !== 21'h0F0A03 || bus.instr_valid !== 1'b1 || bus.busy !== 1'b1) begin miscompares++; $display("FAIL fdl_start: got %h/%b busy %b expected 0f0a03/1 1", bus.instruction, bus.instr_valid, bus.busy); end
    bus.load_valid = 1'b1;
    bus.load_data  = 21'h012345;
    tick();
    vectors++; if (bus.instr_valid !== 1'b0 || bus.instruction !== 21'h0F0A03) begin miscompares++; $display("FAIL fdl_word0: got %h/%b expected 0f0a03/0", bus.instruction, bus.instr_valid); end
    bus.load_valid = 1'b0;
    tick();
    vectors++; if (bus.busy !== 1'b1 || bus.instr_valid !== 1'b0 || bus.instruction !== 21'h0F0A03) begin miscompares++; $display("FAIL fdl_stall: busy %b got %h/%b expected 1 0f0a03/0", bus.busy, bus.instruction, bus.instr_valid); end
    bus.load_valid = 1'b1;
    bus.load_data  = 21'h0ABCDE;
    bus.load_last  = 1'b1;
    tick();
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    vectors++; if (bus.load_done !== 1'b1 || bus.instr_valid !== 1'b0 || bus.instruction !== 21'h0F0A03) begin miscompares++; $display("FAIL fdl_exit: done %b got %h/%b expected 1 0f0a03/0", bus.load_done, bus.instruction, bus.instr_valid); end
    tick();
    vectors++; if (bus.instruction !== 21'h0ABCDE || bus.instr_valid !== 1'b1) begin miscompares++; $display("FAIL fdl_resume: got %h/%b expected 0abcde/1", bus.instruction, bus.instr_valid); end
    bus.pc = 4'd3;
    tick();
    vectors++; if (bus.instruction !== 21'h0) begin miscompares++; $display("FAIL fdl_masked: got %h expected 000000", bus.instruction); end
    bus.fetch_en = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = 21'h150000 + 21'(i);
      tick();
    end
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL rml_loading: got %b expected 1", bus.busy); end
    reset = 1'b1;
    #1;
    vectors++; if (bus.busy !== 1'b0 || bus.load_done !== 1'b0) begin miscompares++; $display("FAIL rml_abort: busy %b done %b expected 0 0", bus.busy, bus.load_done); end
    bus.load_valid = 1'b0;
    tick();
    reset = 1'b0;
    bus.fetch_en = 1'b1;
    bus.pc       = 4'd0;
    tick();
    vectors++; if (bus.instruction !== 21'h0 || bus.instr_valid !== 1'b1 || bus.load_done !== 1'b0) begin miscompares++; $display("FAIL rml_fetch0: got %h/%b done %b expected 000000/1 0", bus.instruction, bus.instr_valid, bus.load_done); end
    bus.fetch_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    bus.load_valid = 1'b1;
    bus.load_data  = 21'h1ABCDE;
    tick();
    bus.load_data  = 21'h02468A;
    bus.load_last  = 1'b1;
    tick();
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    tick();
    bus.load_start = 1'b1;
    bus.fetch_en   = 1'b1;
    bus.pc         = 4'd1;
    tick();
    bus.load_start = 1'b0;
    bus.fetch_en   = 1'b0;
    vectors++; if (bus.instruction !== 21'h02468A || bus.instr_valid !== 1'b1 || bus.busy !== 1'b1) begin miscompares++; $display("FAIL b2b_same_edge: got %h/%b busy %b expected 02468a/1 1", bus.instruction, bus.instr_valid, bus.busy); end
    bus.load_valid = 1'b1;
    bus.load_data  = 21'h000111;
    bus.load_last  = 1'b1;
    tick();
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    vectors++; if (bus.load_done !== 1'b1) begin miscompares++; $display("FAIL b2b_done: got %b expected 1", bus.load_done); end
    bus.fetch_en = 1'b1;
    bus.pc       = 4'd1;
    tick();
    vectors++; if (bus.instruction !== 21'h0) begin miscompares++; $display("FAIL b2b_old_masked: got %h expected 000000", bus.instruction); end
    bus.pc = 4'd0;
    tick();
    vectors++; if (bus.instruction !== 21'h000111) begin miscompares++; $display("FAIL b2b_new_word: got %h expected 000111", bus.instruction); end
    bus.fetch_en = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    test_reset();
    test_short_load();
    test_full_load();
    test_fetch_during_load();
    test_reset_mid_load();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
